gate_reduce_pipe: RTL and testbench

Parametrised, pipelined N-input reduction gate (AND/OR/XOR and their inversions) with valid/ready handshakes on input and output. Generalises the fixed 4-input combinational AND gate into a reusable datapath primitive: configurable width, runtime-selected operation, one register stage per tree level, and full backpressure. It sits between any producer of bit-vectors (e.g. the test sequencers) and a consumer that needs a registered single-bit verdict.

---
 rtl/gate_pkg.sv | 84 ++++++++
 rtl/gate_reduce_node.sv | 27 ++
 rtl/gate_reduce_pipe.sv | 154 +++++++++++++++
 tb/tb_gate_reduce_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared types and helpers for the pipelined reduction gate.
//   gate_op_e     : runtime operation code carried on in_op
//   gate_class_e  : reduction class (AND / OR / XOR) after folding out inversion
//   op_class()    : op code -> reduction class (illegal codes fold to AND)
//   op_identity() : padding value that leaves a reduction of that class unchanged
//   op_is_inverting(), op_is_legal()
//   clog_fanin()  : tree depth needed to reduce n leaves with a given fan-in
//   stage_offset(): bit offset of a level's input slice in the flat tree bus
// -----------------------------------------------------------------------------
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        CLS_AND = 2'd0,
        CLS_OR  = 2'd1,
        CLS_XOR = 2'd2
    } gate_class_e;

    // Illegal codes are deliberately folded into the AND class.
    function automatic gate_class_e op_class(input gate_op_e op);
        gate_class_e cls;
        case (op)
            OP_OR, OP_NOR:   cls = CLS_OR;
            OP_XOR, OP_XNOR: cls = CLS_XOR;
            default:         cls = CLS_AND;
        endcase
        return cls;
    endfunction

    function automatic logic op_identity(input gate_class_e cls);
        return (cls == CLS_AND);
    endfunction

    function automatic logic op_is_inverting(input gate_op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic op_is_legal(input gate_op_e op);
        return !((op == OP_ILL6) || (op == OP_ILL7));
    endfunction

    // Never returns less than one level so that degenerate parameters still
    // reach the explicit elaboration check in the top level.
    function automatic int clog_fanin(input int n, input int fanin);
        int levels;
        int cap;
        levels = 0;
        cap    = 1;
        if (fanin < 2) begin
            return 1;
        end
        while (cap < n) begin
            cap    = cap * fanin;
            levels = levels + 1;
        end
        if (levels < 1) begin
            levels = 1;
        end
        return levels;
    endfunction

    // Level k consumes fanin**(levels-k) bits; slices are packed back to back.
    function automatic int stage_offset(input int k, input int levels, input int fanin);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) begin
            off = off + fanin ** (levels - i);
        end
        return off;
    endfunction

endpackage

// File: rtl/gate_reduce_node.sv
// -----------------------------------------------------------------------------
// gate_reduce_node
// Purely combinational FANIN-input reduction for one tree node.
//   cls_i : reduction class (gate_class_e encoding)
//   in_i  : FANIN input bits
//   f_o   : reduced bit (no inversion; that is applied at the final stage)
// -----------------------------------------------------------------------------
module gate_reduce_node
    import gate_pkg::*;
#(
    parameter int FANIN = 4
) (
    input  logic [1:0]       cls_i,
    input  logic [FANIN-1:0] in_i,
    output logic             f_o
);

    // Unused class encoding 3 behaves as AND, matching the illegal-op rule.
    always_comb begin
        case (cls_i)
            CLS_OR:  f_o = |in_i;
            CLS_XOR: f_o = ^in_i;
            default: f_o = &in_i;
        endcase
    end

endmodule

// File: rtl/gate_reduce_pipe.sv
// -----------------------------------------------------------------------------
// gate_reduce_pipe
// Pipelined N_IN-input reduction gate (AND/OR/XOR and inversions) with
// valid/ready handshakes. One register stage per tree level; latency LEVELS.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake
//   in_data [N_IN-1:0]   : bits to reduce
//   in_op   [2:0]        : 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 illegal
//   out_valid / out_ready: output handshake
//   out_f                : registered reduction result
//   out_err              : set alongside the result of an illegal op
// -----------------------------------------------------------------------------
module gate_reduce_pipe
    import gate_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int FANIN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_f,
    output logic            out_err
);

    localparam int LEVELS = clog_fanin(N_IN, FANIN);
    localparam int LEAVES = FANIN ** LEVELS;
    localparam int SRC_W  = stage_offset(LEVELS, LEVELS, FANIN);

    if (N_IN < 2 || FANIN < 2 || (FANIN & (FANIN - 1)) != 0) begin : g_param_check
        $error("gate_reduce_pipe: need N_IN >= 2 and FANIN a power of 2 >= 2");
    end

    // srcX[k] is what level k consumes: level 0 takes the padded input,
    // level k>0 takes the registers of level k-1.
    logic [LEVELS-1:0] stageValid;
    logic [SRC_W-1:0]  srcData;
    logic [LEVELS-1:0] srcValid;
    logic [LEVELS-1:0] srcInv;
    logic [LEVELS-1:0] srcErr;
    gate_class_e       srcCls [LEVELS];

    gate_op_e          inOp;
    gate_class_e       inCls;
    logic [LEAVES-1:0] leaves;

    assign inOp = gate_op_e'(in_op);

    // Unused leaves take the class identity so they never affect the result.
    always_comb begin
        inCls               = op_class(inOp);
        leaves              = {LEAVES{op_identity(inCls)}};
        leaves[N_IN-1:0]    = in_data;
    end

    assign srcData[LEAVES-1:0] = leaves;
    assign srcValid[0]         = in_valid;
    assign srcInv[0]           = op_is_inverting(inOp);
    assign srcErr[0]           = !op_is_legal(inOp);
    assign srcCls[0]           = inCls;

    // A full pipeline can still accept when the output is draining.
    assign in_ready = out_ready || !(&stageValid);

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int W_IN  = FANIN ** (LEVELS - k);
        localparam int W_OUT = W_IN / FANIN;
        localparam int OFF   = stage_offset(k, LEVELS, FANIN);

        logic [W_OUT-1:0] reduced;
        logic             stageReady;

        for (genvar j = 0; j < W_OUT; j++) begin : g_node
            gate_reduce_node #(
                .FANIN (FANIN)
            ) u_node (
                .cls_i (srcCls[k]),
                .in_i  (srcData[OFF + j*FANIN +: FANIN]),
                .f_o   (reduced[j])
            );
        end

        // Stage k may load if it or any later stage has a hole, or the
        // output is being consumed: this collapses bubbles.
        assign stageReady = out_ready || !(&stageValid[LEVELS-1:k]);

        if (k == LEVELS - 1) begin : g_last
            logic valid_q;
            logic f_q;
            logic err_q;
            logic f_d;

            assign f_d = reduced[0] ^ srcInv[k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    f_q     <= 1'b0;
                    err_q   <= 1'b0;
                end else if (stageReady) begin
                    valid_q <= srcValid[k];
                    if (srcValid[k]) begin
                        f_q   <= f_d;
                        err_q <= srcErr[k];
                    end
                end
            end

            assign stageValid[k] = valid_q;
            assign out_valid     = valid_q;
            assign out_f         = f_q;
            assign out_err       = err_q;
        end else begin : g_mid
            localparam int NEXT_OFF = stage_offset(k + 1, LEVELS, FANIN);

            logic             valid_q;
            logic [W_OUT-1:0] data_q;
            gate_class_e      cls_q;
            logic             inv_q;
            logic             err_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    cls_q   <= CLS_AND;
                    inv_q   <= 1'b0;
                    err_q   <= 1'b0;
                end else if (stageReady) begin
                    valid_q <= srcValid[k];
                    if (srcValid[k]) begin
                        data_q <= reduced;
                        cls_q  <= srcCls[k];
                        inv_q  <= srcInv[k];
                        err_q  <= srcErr[k];
                    end
                end
            end

            assign stageValid[k]                 = valid_q;
            assign srcData[NEXT_OFF +: W_OUT]    = data_q;
            assign srcValid[k+1]                 = valid_q;
            assign srcCls[k+1]                   = cls_q;
            assign srcInv[k+1]                   = inv_q;
            assign srcErr[k+1]                   = err_q;
        end
    end

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_gate_reduce_pipe
// Three instances of gate_reduce_pipe: (8,4) for directed and random traffic,
// (4,2) and (5,4) for exhaustive pattern sweeps including padded leaves.
// -----------------------------------------------------------------------------
module tb_gate_reduce_pipe;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic [NCFG-1:0] drvValid;
    logic [NCFG-1:0] drvReady;
    logic [7:0]      drvData [NCFG];
    logic [2:0]      drvOp   [NCFG];

    logic [NCFG-1:0] monInReady;
    logic [NCFG-1:0] monOutValid;
    logic [NCFG-1:0] monOutF;
    logic [NCFG-1:0] monOutErr;

    int checks   = 0;
    int failures = 0;
    int acceptedCnt [NCFG];
    int emittedCnt  [NCFG];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Result of reducing the low n bits of d with op, straight from the op table.
    function automatic logic [1:0] refModel(input logic [7:0] d, input int n, input logic [2:0] op);
        int  ones;
        logic f;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            ones = ones + int'(d[i]);
        end
        case (op)
            3'd1, 3'd4: f = (ones != 0);
            3'd2, 3'd5: f = ((ones % 2) == 1);
            default:    f = (ones == n);
        endcase
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) begin
            f = !f;
        end
        return {f, (op >= 3'd6)};
    endfunction

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int NC = (c == 0) ? 8 : ((c == 1) ? 4 : 5);
        localparam int FC = (c == 1) ? 2 : 4;
        localparam int LV = 2;

        logic       inReady;
        logic       outValid;
        logic       outF;
        logic       outErr;
        logic [1:0] expQ [$];
        logic       stallPrev = 1'b0;

        gate_reduce_pipe #(
            .N_IN  (NC),
            .FANIN (FC)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (drvValid[c]),
            .in_ready  (inReady),
            .in_data   (drvData[c][NC-1:0]),
            .in_op     (drvOp[c]),
            .out_valid (outValid),
            .out_ready (drvReady[c]),
            .out_f     (outF),
            .out_err   (outErr)
        );

        assign monInReady[c]  = inReady;
        assign monOutValid[c] = outValid;
        assign monOutF[c]     = outF;
        assign monOutErr[c]   = outErr;

        // Mid-cycle look at the handshake that will resolve on the next edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                expQ.delete();
                acceptedCnt[c] = 0;
                emittedCnt[c]  = 0;
                stallPrev      = 1'b0;
                checkOutput($sformatf("c%0d_rst_valid", c), 32'(outValid), 32'd0);
                checkOutput($sformatf("c%0d_rst_f", c), 32'(outF), 32'd0);
                checkOutput($sformatf("c%0d_rst_err", c), 32'(outErr), 32'd0);
            end else begin
                checkOutput($sformatf("c%0d_in_ready", c), 32'(inReady),
                            32'((expQ.size() < LV) || drvReady[c]));
                if (stallPrev) begin
                    checkOutput($sformatf("c%0d_hold_valid", c), 32'(outValid), 32'd1);
                end
                if (outValid) begin
                    if (expQ.size() == 0) begin
                        checkOutput($sformatf("c%0d_spurious_valid", c), 32'(outValid), 32'd0);
                    end else begin
                        checkOutput($sformatf("c%0d_out_f", c), 32'(outF), 32'(expQ[0][1]));
                        checkOutput($sformatf("c%0d_out_err", c), 32'(outErr), 32'(expQ[0][0]));
                    end
                end
                if (outValid && drvReady[c]) begin
                    if (expQ.size() > 0) begin
                        void'(expQ.pop_front());
                    end
                    emittedCnt[c]++;
                end
                if (drvValid[c] && inReady) begin
                    expQ.push_back(refModel(drvData[c], NC, drvOp[c]));
                    acceptedCnt[c]++;
                end
                stallPrev = outValid && !drvReady[c];
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int c, input logic v, input logic [7:0] d, input logic [2:0] op);
        drvValid[c] = v;
        drvData[c]  = d;
        drvOp[c]    = op;
    endtask

    // One transaction on the (8,4) instance with out_ready high: result
    // must appear exactly one cycle after the accepting edge.
    task automatic sendOne(input string name, input logic [7:0] d, input logic [2:0] op,
                           input logic expF, input logic expErr);
        applyStimulus(0, 1'b1, d, op);
        #1 checkOutput({name, "_in_ready"}, 32'(monInReady[0]), 32'd1);
        nextCycle();
        applyStimulus(0, 1'b0, d, op);
        #1 checkOutput({name, "_not_early"}, 32'(monOutValid[0]), 32'd0);
        nextCycle();
        #1;
        checkOutput({name, "_valid"}, 32'(monOutValid[0]), 32'd1);
        checkOutput({name, "_f"}, 32'(monOutF[0]), 32'(expF));
        checkOutput({name, "_err"}, 32'(monOutErr[0]), 32'(expErr));
    endtask

    task automatic drain(input int c);
        int budget;
        nextCycle();
        applyStimulus(c, 1'b0, 8'h00, 3'd0);
        drvReady[c] = 1'b1;
        budget = 0;
        while (emittedCnt[c] != acceptedCnt[c] && budget < 20) begin
            nextCycle();
            budget++;
        end
        checkOutput($sformatf("c%0d_drain_count", c), 32'(emittedCnt[c]), 32'(acceptedCnt[c]));
    endtask

    // Every pattern of n bits under each of the six legal ops, random handshakes.
    task automatic runSweep(input int c, input int n);
        int total;
        int p;
        int cyc;
        total = 6 * (1 << n);
        p     = 0;
        cyc   = 0;
        while (p < total && cyc < total * 20) begin
            nextCycle();
            cyc++;
            applyStimulus(c, ($urandom_range(0, 3) != 0), 8'(p % (1 << n)), 3'(p >> n));
            drvReady[c] = ($urandom_range(0, 3) != 0);
            #1;
            if (drvValid[c] && monInReady[c]) begin
                p++;
            end
        end
        checkOutput($sformatf("c%0d_sweep_sent", c), 32'(p), 32'(total));
        drain(c);
        checkOutput($sformatf("c%0d_sweep_accepted", c), 32'(acceptedCnt[c]), 32'(total));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bpData [4];
        logic [2:0] bpOp   [4];
        logic       bpExp  [4];
        int         p;
        int         got;

        bpData = '{8'hFF, 8'hFE, 8'h00, 8'h07};
        bpOp   = '{3'd0, 3'd0, 3'd1, 3'd2};
        bpExp  = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        drvValid = '0;
        drvReady = '1;
        for (int c = 0; c < NCFG; c++) begin
            drvData[c] = 8'h00;
            drvOp[c]   = 3'd0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(monOutValid[0]), 32'd0);
        checkOutput("reset_out_f", 32'(monOutF[0]), 32'd0);
        checkOutput("reset_out_err", 32'(monOutErr[0]), 32'd0);
        rst_n = 1'b1;
        #1 checkOutput("post_reset_in_ready", 32'(monInReady[0]), 32'd1);

        // Basic operations with the consumer always ready.
        sendOne("and_ff",  8'hFF, 3'd0, 1'b1, 1'b0);
        sendOne("and_fe",  8'hFE, 3'd0, 1'b0, 1'b0);
        sendOne("or_00",   8'h00, 3'd1, 1'b0, 1'b0);
        sendOne("xor_07",  8'h07, 3'd2, 1'b1, 1'b0);
        sendOne("nand_ff", 8'hFF, 3'd3, 1'b0, 1'b0);
        sendOne("nor_00",  8'h00, 3'd4, 1'b1, 1'b0);
        sendOne("xnor_03", 8'h03, 3'd5, 1'b1, 1'b0);
        sendOne("ill6_ff", 8'hFF, 3'd6, 1'b1, 1'b1);
        sendOne("after_ill", 8'hFF, 3'd0, 1'b1, 1'b0);
        sendOne("ill7_7f", 8'h7F, 3'd7, 1'b0, 1'b1);

        // Backpressure: consumer stalled, four inputs offered back to back.
        nextCycle();
        drvReady[0] = 1'b0;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (p < 4) begin
                applyStimulus(0, 1'b1, bpData[p], bpOp[p]);
            end
            #1;
            if (monInReady[0] && p < 4) begin
                p++;
            end
            nextCycle();
        end
        checkOutput("bp_accepted_while_stalled", 32'(p), 32'd2);
        if (p < 4) begin
            applyStimulus(0, 1'b1, bpData[p], bpOp[p]);
        end
        #1 checkOutput("bp_in_ready_low", 32'(monInReady[0]), 32'd0);

        drvReady[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got < 4; i++) begin
            if (p < 4) begin
                applyStimulus(0, 1'b1, bpData[p], bpOp[p]);
            end else begin
                applyStimulus(0, 1'b0, 8'h00, 3'd0);
            end
            #1;
            if (monOutValid[0]) begin
                checkOutput($sformatf("bp_order%0d_f", got), 32'(monOutF[0]), 32'(bpExp[got]));
                checkOutput($sformatf("bp_order%0d_cycle", got), 32'(i), 32'(got));
                got++;
            end
            if (drvValid[0] && monInReady[0] && p < 4) begin
                p++;
            end
            nextCycle();
        end
        checkOutput("bp_emitted", 32'(got), 32'd4);
        checkOutput("bp_all_accepted", 32'(p), 32'd4);
        applyStimulus(0, 1'b0, 8'h00, 3'd0);

        // Reset with two transactions in flight.
        nextCycle();
        drvReady[0] = 1'b0;
        applyStimulus(0, 1'b1, 8'hFF, 3'd0);
        nextCycle();
        applyStimulus(0, 1'b1, 8'h00, 3'd4);
        nextCycle();
        applyStimulus(0, 1'b0, 8'h00, 3'd0);
        #1 checkOutput("mid_full_valid", 32'(monOutValid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(monOutValid[0]), 32'd0);
        checkOutput("mid_rst_f", 32'(monOutF[0]), 32'd0);
        checkOutput("mid_rst_err", 32'(monOutErr[0]), 32'd0);
        repeat (2) nextCycle();
        rst_n       = 1'b1;
        drvReady[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("after_rst_idle%0d", i), 32'(monOutValid[0]), 32'd0);
        end
        sendOne("after_rst_and_0f", 8'h0F, 3'd0, 1'b0, 1'b0);

        // Random traffic on the 8-input instance, including illegal ops.
        for (int i = 0; i < 400; i++) begin
            nextCycle();
            applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          3'($urandom_range(0, 7)));
            drvReady[0] = ($urandom_range(0, 3) != 0);
        end
        drain(0);

        runSweep(1, 4);
        runSweep(2, 5);

        nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
